// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master arbiter for the memory bus with a per-transaction watchdog
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_data_valid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_cyc,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_data_valid,
    output logic [DW-1:0] m1_rdata,
    output logic          s_cyc,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_ack,
    input  logic          s_data_valid,
    input  logic [DW-1:0] s_rdata,
    output logic [1:0]    grant,
    output logic          timeout_err
);
    localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, WAIT_DATA = 2'd2;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    state_q, state_d, grant_q, grant_d;
    logic          last_q, last_d, we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own, o_cyc, o_we, in_cmd, in_wait, pick1;
    logic          expire, abort, real_ack, real_dv, done, tmo, ack_f, dv_f;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, rdata_f;

    assign own     = grant_q[1];
    assign o_cyc   = own ? m1_cyc : m0_cyc;
    assign o_we    = own ? m1_we : m0_we;
    assign o_addr  = own ? m1_addr : m0_addr;
    assign o_wdata = own ? m1_wdata : m0_wdata;
    assign in_cmd  = state_q == CMD;
    assign in_wait = state_q == WAIT_DATA;
    assign pick1   = m1_cyc & (~m0_cyc | ~last_q);

    assign expire   = (TIMEOUT_CYCLES != 0) && (in_cmd || in_wait) && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign abort    = in_cmd & ~o_cyc;
    assign real_ack = in_cmd & o_cyc & s_ack;
    assign real_dv  = in_wait ? s_data_valid : real_ack & s_data_valid;
    assign done     = in_cmd ? real_ack & (we_q | s_data_valid) : in_wait & s_data_valid;
    // A real completion or a master abort in the expiry cycle suppresses the watchdog
    assign tmo      = expire & ~done & ~abort;
    assign ack_f    = real_ack | (tmo & in_cmd);
    assign dv_f     = real_dv | (tmo & ~we_q);
    assign rdata_f  = real_dv ? s_rdata : '0;

    assign s_cyc   = in_cmd & o_cyc;
    assign s_we    = in_cmd & o_we;
    assign s_addr  = in_cmd ? o_addr : '0;
    assign s_wdata = in_cmd ? o_wdata : '0;

    assign m0_ack        = grant_q[0] & ack_f;
    assign m0_data_valid = grant_q[0] & dv_f;
    assign m0_rdata      = grant_q[0] ? rdata_f : '0;
    assign m1_ack        = grant_q[1] & ack_f;
    assign m1_data_valid = grant_q[1] & dv_f;
    assign m1_rdata      = grant_q[1] ? rdata_f : '0;
    assign grant         = grant_q;
    assign timeout_err   = tmo;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (m0_cyc | m1_cyc) begin
                state_d = CMD;
                grant_d = pick1 ? 2'b10 : 2'b01;
                we_d    = pick1 ? m1_we : m0_we;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (abort | done | tmo) begin
                state_d = IDLE;
                grant_d = 2'b00;
                last_d  = own;
            end else if (real_ack) begin
                state_d = WAIT_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
